decode_queue: RTL and testbench

Parametrised successor to the single-register decode stage. Buffers fetched instructions in a DEPTH-entry FIFO, decodes the FIFO head into read-stage control fields, and presents them in an output register behind a valid/ready handshake. Adds three things the previous stage lacks: fetch/read decoupling, an optional load-use interlock bubble, and automatic discard of wrong-path instructions queued behind a PC-writing instruction. Sits between fetch and register read.

---
 rtl/decode_queue.sv | 207 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: a FIFO between fetch and register read. The instruction at
// the FIFO head is decoded, and the decoded fields are loaded into an output
// register that uses a valid/ready handshake.
//
// The queue has three extra behaviours:
// - An optional load-use bubble.
// - When a PC-writing instruction leaves the FIFO, the younger (wrong-path)
//   entries queued behind it are discarded.
// - A flush input clears the FIFO and the output register.
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   flush                  discard the FIFO and the output register
//   in_valid/in_ready      fetch handshake; in_instruction, in_pc are the payload
//   out_valid/out_ready    read-stage handshake; out_* carry the decoded fields
//   is_pc_changing         combinational; a PC-writing head is popped this cycle
//   occupancy              number of FIFO entries
module decode_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PC_REG         = 31,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instruction,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_is_non_zero_active,
  output logic [3:0]                 out_cnvz_mask,
  output logic [3:0]                 out_operation,
  output logic [4:0]                 out_target_register,
  output logic [4:0]                 out_left_register,
  output logic [4:0]                 out_right_register,
  output logic [4:0]                 out_address_register,
  output logic [1:0]                 out_adjustment_operation,
  output logic [XLEN-1:0]            out_adjustment_value,
  output logic                       out_is_reading_memory,
  output logic                       out_is_writing_memory,
  output logic                       out_has_flushed,
  output logic                       is_pc_changing,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     head;
  logic [4:0]      d_target, d_left, d_right, d_addr;
  logic [3:0]      d_op;
  logic [1:0]      d_adj_op;
  logic [XLEN-1:0] d_adj;
  logic            d_rd, d_wr, d_pc_write;
  logic            bubble, pop, push, discard;

  assign head     = instr_mem[rd_ptr];
  assign d_target = head[22:18];

  // Decode the FIFO head into read-stage control fields
  always_comb begin
    d_op     = head[26:23];
    d_left   = head[16:12];
    d_right  = head[11:7];
    d_addr   = head[15:11];
    d_adj_op = head[6:5];
    d_adj    = '0;
    d_rd     = 1'b0;
    d_wr     = 1'b0;
    case (head[26:23])
      4'd14: begin
        d_left   = '0;
        d_right  = '0;
        d_op     = 4'd10;
        d_adj_op = 2'd3;
        case (head[17:16])
          2'd0: begin
            d_rd  = 1'b1;
            d_adj = XLEN'($signed(head[10:0]));
          end
          2'd1: d_adj = XLEN'($signed(head[15:0]));
          2'd2: begin
            d_op   = 4'd12;
            d_left = d_target;
            d_adj  = XLEN'($signed({head[15:0], 16'h0000}));
          end
          default: begin
            d_wr     = 1'b1;
            d_left   = d_target;
            d_adj_op = 2'd0;
            d_adj    = XLEN'($signed(head[10:0]));
          end
        endcase
      end
      4'd15: begin
        d_rd     = 1'b1;
        d_wr     = 1'b1;
        d_addr   = head[6:2];
        d_adj_op = 2'd3;
      end
      default: begin
        if (head[17]) begin
          d_adj = XLEN'($signed(head[4:0]));
        end else begin
          d_right  = '0;
          d_adj_op = 2'd3;
          d_adj    = XLEN'($signed(head[11:0]));
        end
      end
    endcase
  end

  // A pure store does not write its target register, so it cannot write the PC
  assign d_pc_write = (d_target == 5'(PC_REG)) && !(d_wr && !d_rd);

  // Hold the head back for one cycle when it consumes the result of a load
  // that is leaving the output register
  assign bubble = (LOAD_USE_STALL != 0) && out_valid && out_ready &&
                  out_is_reading_memory && !out_is_writing_memory &&
                  (out_target_register != 5'd0) &&
                  ((d_left  == out_target_register) ||
                   (d_right == out_target_register) ||
                   (d_addr  == out_target_register));

  assign pop = !reset && !flush && (count != '0) &&
               (!out_valid || out_ready) && !bubble;
  assign discard        = pop && d_pc_write;
  assign is_pc_changing = discard;
  assign in_ready       = !reset && (count != CW'(DEPTH));
  assign push           = in_valid && in_ready && !flush && !discard;
  assign occupancy      = count;

  // FIFO storage (no reset needed: occupancy guards every read)
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers, occupancy and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr                   <= '0;
      rd_ptr                   <= '0;
      count                    <= '0;
      out_valid                <= 1'b0;
      out_pc                   <= '0;
      out_is_non_zero_active   <= 1'b0;
      out_cnvz_mask            <= '0;
      out_operation            <= '0;
      out_target_register      <= '0;
      out_left_register        <= '0;
      out_right_register       <= '0;
      out_address_register     <= '0;
      out_adjustment_operation <= '0;
      out_adjustment_value     <= '0;
      out_is_reading_memory    <= 1'b0;
      out_is_writing_memory    <= 1'b0;
      out_has_flushed          <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop) begin
        out_valid                <= 1'b1;
        out_pc                   <= pc_mem[rd_ptr];
        out_is_non_zero_active   <= head[31];
        out_cnvz_mask            <= head[30:27];
        out_operation            <= d_op;
        out_target_register      <= d_target;
        out_left_register        <= d_left;
        out_right_register       <= d_right;
        out_address_register     <= d_addr;
        out_adjustment_operation <= d_adj_op;
        out_adjustment_value     <= d_adj;
        out_is_reading_memory    <= d_rd;
        out_is_writing_memory    <= d_wr;
        out_has_flushed          <= d_pc_write;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Entries younger than a PC-writing instruction are on the wrong path
      if (discard) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue. It uses a table of
// single-instruction decode vectors, plus hand-written sequences for fill and
// drain, the load-use bubble, the wrong-path discard and flush.
// A second instance, with the load-use stall disabled, shares all of the inputs.
module tb_decode_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, is_pc_changing;
  logic [31:0] out_pc, out_adjustment_value;
  logic        out_is_non_zero_active, out_is_reading_memory, out_is_writing_memory, out_has_flushed;
  logic [3:0]  out_cnvz_mask, out_operation;
  logic [4:0]  out_target_register, out_left_register, out_right_register, out_address_register;
  logic [1:0]  out_adjustment_operation;
  logic [2:0]  occupancy;

  logic        n_in_ready, n_out_valid, n_is_pc_changing;
  logic [31:0] n_out_pc, n_out_adjustment_value;
  logic        n_out_is_non_zero_active, n_out_is_reading_memory, n_out_is_writing_memory, n_out_has_flushed;
  logic [3:0]  n_out_cnvz_mask, n_out_operation;
  logic [4:0]  n_out_target_register, n_out_left_register, n_out_right_register, n_out_address_register;
  logic [1:0]  n_out_adjustment_operation;
  logic [2:0]  n_occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  decode_queue u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_is_non_zero_active(out_is_non_zero_active), .out_cnvz_mask(out_cnvz_mask),
    .out_operation(out_operation), .out_target_register(out_target_register),
    .out_left_register(out_left_register), .out_right_register(out_right_register),
    .out_address_register(out_address_register), .out_adjustment_operation(out_adjustment_operation),
    .out_adjustment_value(out_adjustment_value), .out_is_reading_memory(out_is_reading_memory),
    .out_is_writing_memory(out_is_writing_memory), .out_has_flushed(out_has_flushed),
    .is_pc_changing(is_pc_changing), .occupancy(occupancy)
  );

  decode_queue #(.LOAD_USE_STALL(0)) u_nostall (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_is_non_zero_active(n_out_is_non_zero_active), .out_cnvz_mask(n_out_cnvz_mask),
    .out_operation(n_out_operation), .out_target_register(n_out_target_register),
    .out_left_register(n_out_left_register), .out_right_register(n_out_right_register),
    .out_address_register(n_out_address_register), .out_adjustment_operation(n_out_adjustment_operation),
    .out_adjustment_value(n_out_adjustment_value), .out_is_reading_memory(n_out_is_reading_memory),
    .out_is_writing_memory(n_out_is_writing_memory), .out_has_flushed(n_out_has_flushed),
    .is_pc_changing(n_is_pc_changing), .occupancy(n_occupancy)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        nz;
    logic [3:0]  cnvz;
    logic [3:0]  op;
    logic [4:0]  tgt;
    logic [4:0]  left;
    logic [4:0]  right;
    logic [4:0]  addr;
    logic [1:0]  adj_op;
    logic [31:0] adj;
    logic        rd;
    logic        wr;
    logic        fl;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] ADDI  = 32'h1404_5003;
  localparam logic [31:0] LD_R5 = 32'h0714_0004;
  localparam logic [31:0] ADD65 = 32'h009A_5080;
  localparam logic [31:0] JUMP  = 32'h077D_0040;

  initial begin
    //            instr          pc      nz cnvz op  tgt left right addr adjop adj            rd wr fl
    vecs[0] = '{32'h1404_5003, 32'h100, 0, 2,  8,  1,  5,  0,  10, 3, 32'h0000_0003, 0, 0, 0};
    vecs[1] = '{32'hFF14_07FF, 32'h104, 1, 15, 10, 5,  0,  0,  0,  3, 32'hFFFF_FFFF, 1, 0, 0};
    vecs[2] = '{32'h070D_8001, 32'h108, 0, 0,  10, 3,  0,  0,  16, 3, 32'hFFFF_8001, 0, 0, 0};
    vecs[3] = '{32'h071E_1234, 32'h10C, 0, 0,  12, 7,  7,  0,  2,  3, 32'h1234_0000, 0, 0, 0};
    vecs[4] = '{32'h077F_0400, 32'h110, 0, 0,  10, 31, 31, 0,  0,  0, 32'hFFFF_FC00, 0, 1, 0};
    vecs[5] = '{32'h0790_307C, 32'h114, 0, 0,  15, 4,  3,  0,  31, 3, 32'h0000_0000, 1, 1, 0};
    vecs[6] = '{32'h07FC_307C, 32'h118, 0, 0,  15, 31, 3,  0,  31, 3, 32'h0000_0000, 1, 1, 1};
    vecs[7] = '{32'h299A_9150, 32'h11C, 0, 5,  3,  6,  9,  2,  18, 2, 32'hFFFF_FFF0, 0, 0, 0};
    vecs[8] = '{32'h007C_0800, 32'h120, 0, 0,  0,  31, 0,  0,  1,  3, 32'hFFFF_F800, 0, 0, 1};

    // Reset: an offer made during reset is refused
    in_valid = 1'b1;
    in_instruction = ADDI;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_pc_changing", is_pc_changing, 0);
    chk("reset_has_flushed", out_has_flushed, 0);
    chk("reset_adj", out_adjustment_value, 0);
    chk("reset_nostall_out_valid", n_out_valid, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    step();

    // Decode table: push one instruction, check latency and the decoded fields
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instruction = vecs[i].instr;
      in_pc = vecs[i].pc;
      out_ready = 1'b0;
      step();
      chk($sformatf("v%0d_latency", i), out_valid, 0);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_pc_changing", i), is_pc_changing, vecs[i].fl);
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_nz", i), out_is_non_zero_active, vecs[i].nz);
      chk($sformatf("v%0d_cnvz", i), out_cnvz_mask, vecs[i].cnvz);
      chk($sformatf("v%0d_op", i), out_operation, vecs[i].op);
      chk($sformatf("v%0d_tgt", i), out_target_register, vecs[i].tgt);
      chk($sformatf("v%0d_left", i), out_left_register, vecs[i].left);
      chk($sformatf("v%0d_right", i), out_right_register, vecs[i].right);
      chk($sformatf("v%0d_addr", i), out_address_register, vecs[i].addr);
      chk($sformatf("v%0d_adj_op", i), out_adjustment_operation, vecs[i].adj_op);
      chk($sformatf("v%0d_adj", i), out_adjustment_value, vecs[i].adj);
      chk($sformatf("v%0d_rd", i), out_is_reading_memory, vecs[i].rd);
      chk($sformatf("v%0d_wr", i), out_is_writing_memory, vecs[i].wr);
      chk($sformatf("v%0d_flushed", i), out_has_flushed, vecs[i].fl);
      chk($sformatf("v%0d_occ", i), occupancy, 0);
      out_ready = 1'b1;
      step();
      chk($sformatf("v%0d_consumed", i), out_valid, 0);
    end

    // Fill and drain: five accepted (one in the output register), the sixth refused
    out_ready = 1'b0;
    in_instruction = ADDI;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h200 + 32'(4 * i);
      step();
      chk($sformatf("fill_occ%0d", i), occupancy, (i == 0) ? 1 : i);
    end
    in_pc = 32'h300;
    #1;
    chk("full_in_ready", in_ready, 0);
    step();
    chk("full_occ_a", occupancy, 4);
    step();
    chk("full_occ_b", occupancy, 4);
    chk("full_in_ready_b", in_ready, 0);
    chk("full_stable_pc", out_pc, 32'h200);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("drain_valid%0d", k), out_valid, 1);
      chk($sformatf("drain_pc%0d", k), out_pc, 32'h200 + 32'(4 * k));
      chk($sformatf("drain_occ%0d", k), occupancy, 4 - k);
    end
    step();
    chk("drain_done", out_valid, 0);

    // Load-use: ld r5 then add r6,r5,r1; one bubble only with the stall enabled
    in_valid = 1'b1;
    in_instruction = LD_R5;
    in_pc = 32'h400;
    step();
    in_instruction = ADD65;
    in_pc = 32'h404;
    step();
    in_valid = 1'b0;
    chk("lu_ld_pc", out_pc, 32'h400);
    chk("lu_ld_pc_n", n_out_pc, 32'h400);
    step();
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_bubble_occ", occupancy, 1);
    chk("lu_nostall_valid", n_out_valid, 1);
    chk("lu_nostall_pc", n_out_pc, 32'h404);
    step();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_pc", out_pc, 32'h404);
    chk("lu_nostall_done", n_out_valid, 0);
    step();
    chk("lu_done", out_valid, 0);

    // Wrong-path discard: filler in output, jump at head, two younger entries behind
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instruction = ADDI;
    in_pc = 32'h4F0;
    step();
    in_instruction = JUMP;
    in_pc = 32'h500;
    step();
    in_instruction = ADDI;
    in_pc = 32'h504;
    step();
    in_pc = 32'h508;
    step();
    in_pc = 32'h50C;
    #1;
    chk("jmp_occ", occupancy, 3);
    chk("jmp_held_no_change", is_pc_changing, 0);
    out_ready = 1'b1;
    #1;
    chk("jmp_pc_changing", is_pc_changing, 1);
    step();
    in_valid = 1'b0;
    chk("jmp_out_pc", out_pc, 32'h500);
    chk("jmp_has_flushed", out_has_flushed, 1);
    chk("jmp_occ_zero", occupancy, 0);
    #1;
    chk("jmp_pc_changing_once", is_pc_changing, 0);
    step();
    chk("jmp_younger_gone_a", out_valid, 0);
    step();
    chk("jmp_younger_gone_b", out_valid, 0);
    chk("jmp_occ_end", occupancy, 0);

    // Flush mid-stream with three entries queued and an offer in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h600 + 32'(4 * i);
      step();
    end
    chk("fl_occ3", occupancy, 3);
    flush = 1'b1;
    in_pc = 32'h6F0;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", out_valid, 0);
    in_valid = 1'b1;
    in_pc = 32'h700;
    step();
    in_valid = 1'b0;
    chk("fl_after_latency", out_valid, 0);
    step();
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_pc", out_pc, 32'h700);
    chk("fl_after_flushed", out_has_flushed, 0);
    step();
    chk("fl_after_done", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
